// File: rtl/mem_wb_register_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_register_pkg
// Shared definitions for the MEM/WB pipeline register slice: load-size
// encodings, the hard-wired zero register index and default widths.
// No ports.
// -----------------------------------------------------------------------------
package mem_wb_register_pkg;

   localparam int N_BITS_DEFAULT        = 32;
   localparam int REG_ADDR_BITS_DEFAULT = 5;

   // Register $0 always reads zero and is never written
   localparam int ZERO_REG = 0;

   // Load size as carried down the pipeline from decode
   typedef enum logic [1:0] {
      LOAD_WORD = 2'b00,
      LOAD_HALF = 2'b01,
      LOAD_BYTE = 2'b10,
      LOAD_RSVD = 2'b11   // reserved, handled like a word load
   } load_size_e;

endpackage : mem_wb_register_pkg

// File: rtl/mem_wb_register_if.sv
// -----------------------------------------------------------------------------
// mem_wb_register_if
// Bundles the MEM-side inputs, the pipeline control (Stall/Flush) and the
// WB-side outputs of the MEM/WB register.
//   master : MEM stage / hazard unit side (drives MEM_*, Stall, Flush)
//   slave  : the pipeline register itself (drives WB_*)
// -----------------------------------------------------------------------------
interface mem_wb_register_if
   import mem_wb_register_pkg::*;
#(
   parameter int N_BITS        = N_BITS_DEFAULT,
   parameter int REG_ADDR_BITS = REG_ADDR_BITS_DEFAULT
);
   // Pipeline control
   logic                     Stall;
   logic                     Flush;
   // MEM stage inputs
   logic                     MEM_Valid;
   logic                     MEM_RegWrite;
   logic                     MEM_MemtoReg;
   logic [1:0]               MEM_Load_Size;
   logic                     MEM_Load_Unsigned;
   logic [REG_ADDR_BITS-1:0] MEM_Write_Register;
   logic [N_BITS-1:0]        MEM_ALU_Result;
   logic [N_BITS-1:0]        MEM_Read_Data;
   // WB stage outputs
   logic                     WB_Valid;
   logic                     WB_RegWrite;
   logic [N_BITS-1:0]        WB_MemtoReg_Selector;
   logic [REG_ADDR_BITS-1:0] WB_Write_Register;
   logic [N_BITS-1:0]        WB_ALU_Result;
   logic [N_BITS-1:0]        WB_Load_Data;
   logic                     WB_Misaligned;

   modport master (
      output Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_Load_Size,
             MEM_Load_Unsigned, MEM_Write_Register, MEM_ALU_Result, MEM_Read_Data,
      input  WB_Valid, WB_RegWrite, WB_MemtoReg_Selector, WB_Write_Register,
             WB_ALU_Result, WB_Load_Data, WB_Misaligned
   );

   modport slave (
      input  Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_Load_Size,
             MEM_Load_Unsigned, MEM_Write_Register, MEM_ALU_Result, MEM_Read_Data,
      output WB_Valid, WB_RegWrite, WB_MemtoReg_Selector, WB_Write_Register,
             WB_ALU_Result, WB_Load_Data, WB_Misaligned
   );

endinterface : mem_wb_register_if

// File: rtl/mem_wb_register_load_aligner.sv
// -----------------------------------------------------------------------------
// mem_wb_register_load_aligner
// Purely combinational sub-word load alignment. Selects the addressed
// halfword/byte lane of the raw memory word and sign- or zero-extends it.
// Ports:
//   read_data_i   raw word from data memory
//   offset_i      byte offset, address bits [1:0]
//   size_i        load size (word / half / byte / reserved=word)
//   unsigned_i    1 = zero-extend, 0 = sign-extend
//   load_data_o   aligned, extended data
//   misaligned_o  access not naturally aligned for its size (unqualified)
// -----------------------------------------------------------------------------
module mem_wb_register_load_aligner
   import mem_wb_register_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEFAULT
) (
   input  logic [N_BITS-1:0] read_data_i,
   input  logic [1:0]        offset_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   output logic [N_BITS-1:0] load_data_o,
   output logic              misaligned_o
);

   logic [15:0] half_s;
   logic [7:0]  byte_s;

   // Lane selection, extension and natural-alignment check
   always_comb begin
      half_s       = offset_i[1] ? read_data_i[31:16] : read_data_i[15:0];
      byte_s       = read_data_i[{offset_i, 3'b000} +: 8];
      load_data_o  = read_data_i;
      misaligned_o = 1'b0;
      case (load_size_e'(size_i))
         LOAD_HALF: begin
            load_data_o  = {{(N_BITS-16){~unsigned_i & half_s[15]}}, half_s};
            misaligned_o = offset_i[0];
         end
         LOAD_BYTE: begin
            load_data_o  = {{(N_BITS-8){~unsigned_i & byte_s[7]}}, byte_s};
            misaligned_o = 1'b0;
         end
         default: begin
            // Word and the reserved encoding: full word, must be word aligned
            load_data_o  = read_data_i;
            misaligned_o = (offset_i != 2'b00);
         end
      endcase
   end

endmodule : mem_wb_register_load_aligner

// File: rtl/mem_wb_register.sv
// -----------------------------------------------------------------------------
// mem_wb_register
// MEM/WB pipeline register. Captures ALU result, aligned load data and WB
// control at the end of MEM; one cycle latency. Priority on each edge:
// reset > Flush (bubble) > Stall (hold) > load.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    mem_wb_register_if.slave: Stall/Flush, MEM_* inputs, WB_* outputs
// -----------------------------------------------------------------------------
module mem_wb_register
   import mem_wb_register_pkg::*;
#(
   parameter int N_BITS        = N_BITS_DEFAULT,
   parameter int REG_ADDR_BITS = REG_ADDR_BITS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_wb_register_if.slave      bus
);

   logic [N_BITS-1:0]        aligned_s;
   logic                     mis_raw_s;
   logic                     misaligned_s;
   logic                     regwrite_s;
   logic [N_BITS-1:0]        load_data_s;

   logic                     valid_d,    valid_q;
   logic                     regwrite_d, regwrite_q;
   logic                     memtoreg_d, memtoreg_q;
   logic [REG_ADDR_BITS-1:0] rd_d,       rd_q;
   logic [N_BITS-1:0]        alu_d,      alu_q;
   logic [N_BITS-1:0]        load_d,     load_q;
   logic                     mis_d,      mis_q;

   mem_wb_register_load_aligner #(.N_BITS(N_BITS)) u_aligner (
      .read_data_i  (bus.MEM_Read_Data),
      .offset_i     (bus.MEM_ALU_Result[1:0]),
      .size_i       (bus.MEM_Load_Size),
      .unsigned_i   (bus.MEM_Load_Unsigned),
      .load_data_o  (aligned_s),
      .misaligned_o (mis_raw_s)
   );

   // Misalignment only matters for a real load; it kills data and write enable
   always_comb begin
      misaligned_s = bus.MEM_Valid & bus.MEM_MemtoReg & mis_raw_s;
      regwrite_s   = bus.MEM_RegWrite & bus.MEM_Valid & ~misaligned_s &
                     (bus.MEM_Write_Register != REG_ADDR_BITS'(ZERO_REG));
      if (misaligned_s) begin
         load_data_s = '0;
      end else begin
         load_data_s = aligned_s;
      end
   end

   // Next-state selection: bubble beats hold beats capture
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      rd_d       = rd_q;
      alu_d      = alu_q;
      load_d     = load_q;
      mis_d      = mis_q;
      if (bus.Flush) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         rd_d       = '0;
         alu_d      = '0;
         load_d     = '0;
         mis_d      = 1'b0;
      end else if (bus.Stall) begin
         valid_d    = valid_q;
         regwrite_d = regwrite_q;
         memtoreg_d = memtoreg_q;
         rd_d       = rd_q;
         alu_d      = alu_q;
         load_d     = load_q;
         mis_d      = mis_q;
      end else begin
         valid_d    = bus.MEM_Valid;
         regwrite_d = regwrite_s;
         memtoreg_d = bus.MEM_MemtoReg;
         rd_d       = bus.MEM_Write_Register;
         alu_d      = bus.MEM_ALU_Result;
         load_d     = load_data_s;
         mis_d      = misaligned_s;
      end
   end

   // Stage registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         rd_q       <= '0;
         alu_q      <= '0;
         load_q     <= '0;
         mis_q      <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         rd_q       <= rd_d;
         alu_q      <= alu_d;
         load_q     <= load_d;
         mis_q      <= mis_d;
      end
   end

   assign bus.WB_Valid             = valid_q;
   assign bus.WB_RegWrite          = regwrite_q;
   // The write-back mux takes a full-width selector
   assign bus.WB_MemtoReg_Selector = {N_BITS{memtoreg_q}};
   assign bus.WB_Write_Register    = rd_q;
   assign bus.WB_ALU_Result        = alu_q;
   assign bus.WB_Load_Data         = load_q;
   assign bus.WB_Misaligned        = mis_q;

endmodule : mem_wb_register

// File: tb/tb_mem_wb_register.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_register
// Directed self-checking bench for mem_wb_register.
// -----------------------------------------------------------------------------
module tb_mem_wb_register;
   import mem_wb_register_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_wb_register_if #(.N_BITS(32), .REG_ADDR_BITS(5)) bus ();

   mem_wb_register #(.N_BITS(32), .REG_ADDR_BITS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Downstream write-back mux driven by the full-width selector
   logic [31:0] wb_mux;
   assign wb_mux = (bus.WB_MemtoReg_Selector & bus.WB_Load_Data) |
                   (~bus.WB_MemtoReg_Selector & bus.WB_ALU_Result);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r,
                        input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata);
      bus.MEM_Valid          = v;
      bus.MEM_RegWrite       = rw;
      bus.MEM_MemtoReg       = m2r;
      bus.MEM_Load_Size      = sz;
      bus.MEM_Load_Unsigned  = uns;
      bus.MEM_Write_Register = rd;
      bus.MEM_ALU_Result     = alu;
      bus.MEM_Read_Data      = rdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"}, {31'd0, bus.WB_Valid}, 32'd0);
      chk({tag, ".rw"},    {31'd0, bus.WB_RegWrite}, 32'd0);
      chk({tag, ".sel"},   bus.WB_MemtoReg_Selector, 32'd0);
      chk({tag, ".rd"},    {27'd0, bus.WB_Write_Register}, 32'd0);
      chk({tag, ".alu"},   bus.WB_ALU_Result, 32'd0);
      chk({tag, ".load"},  bus.WB_Load_Data, 32'd0);
      chk({tag, ".mis"},   {31'd0, bus.WB_Misaligned}, 32'd0);
   endtask

   initial begin
      clk    = 1'b0;
      reset  = 1'b0;
      checks = 0;
      errors = 0;
      bus.Stall = 1'b0;
      bus.Flush = 1'b0;

      // Reset with random inputs for two edges
      drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 5'($urandom), $urandom, $urandom);
      tick();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 5'($urandom), $urandom, $urandom);
      bus.Stall = 1'($urandom);
      tick();
      chk_all_zero("reset");
      bus.Stall = 1'b0;

      // First capture after reset release
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, LOAD_WORD, 1'b0, 5'd5, 32'h0000_1234, 32'h0);
      tick();
      chk("first.alu",   bus.WB_ALU_Result, 32'h0000_1234);
      chk("first.rw",    {31'd0, bus.WB_RegWrite}, 32'd1);
      chk("first.rd",    {27'd0, bus.WB_Write_Register}, 32'd5);
      chk("first.valid", {31'd0, bus.WB_Valid}, 32'd1);
      chk("first.sel",   bus.WB_MemtoReg_Selector, 32'h0000_0000);
      chk("first.mux",   wb_mux, 32'h0000_1234);

      // Signed byte, lane 3
      drive(1'b1, 1'b1, 1'b1, LOAD_BYTE, 1'b0, 5'd3, 32'h0000_1003, 32'h80FF_7F01);
      tick();
      chk("sbyte3.load", bus.WB_Load_Data, 32'hFFFF_FF80);
      chk("sbyte3.mis",  {31'd0, bus.WB_Misaligned}, 32'd0);
      chk("sbyte3.rw",   {31'd0, bus.WB_RegWrite}, 32'd1);
      chk("sbyte3.sel",  bus.WB_MemtoReg_Selector, 32'hFFFF_FFFF);
      chk("sbyte3.mux",  wb_mux, 32'hFFFF_FF80);

      // Unsigned byte, lane 3
      drive(1'b1, 1'b1, 1'b1, LOAD_BYTE, 1'b1, 5'd3, 32'h0000_1003, 32'h80FF_7F01);
      tick();
      chk("ubyte3.load", bus.WB_Load_Data, 32'h0000_0080);

      // Signed byte, lane 1
      drive(1'b1, 1'b1, 1'b1, LOAD_BYTE, 1'b0, 5'd3, 32'h0000_1001, 32'h80FF_7F01);
      tick();
      chk("sbyte1.load", bus.WB_Load_Data, 32'h0000_007F);

      // Signed halfword, upper half
      drive(1'b1, 1'b1, 1'b1, LOAD_HALF, 1'b0, 5'd4, 32'h0000_2002, 32'h8001_1234);
      tick();
      chk("shalf2.load", bus.WB_Load_Data, 32'hFFFF_8001);
      chk("shalf2.mis",  {31'd0, bus.WB_Misaligned}, 32'd0);

      // Misaligned halfword
      drive(1'b1, 1'b1, 1'b1, LOAD_HALF, 1'b0, 5'd4, 32'h0000_2001, 32'h8001_1234);
      tick();
      chk("mhalf.mis",  {31'd0, bus.WB_Misaligned}, 32'd1);
      chk("mhalf.rw",   {31'd0, bus.WB_RegWrite}, 32'd0);
      chk("mhalf.load", bus.WB_Load_Data, 32'h0000_0000);

      // Word load passes data unchanged
      drive(1'b1, 1'b1, 1'b1, LOAD_WORD, 1'b0, 5'd9, 32'h0000_3000, 32'hCAFE_F00D);
      tick();
      chk("word.load", bus.WB_Load_Data, 32'hCAFE_F00D);

      // Non-load with unaligned ALU result: not misaligned
      drive(1'b1, 1'b1, 1'b0, LOAD_WORD, 1'b0, 5'd9, 32'h0000_0002, 32'h0);
      tick();
      chk("nonload.mis", {31'd0, bus.WB_Misaligned}, 32'd0);
      chk("nonload.rw",  {31'd0, bus.WB_RegWrite}, 32'd1);

      // Invalid instruction: captured but no write, no misaligned flag
      drive(1'b0, 1'b1, 1'b1, LOAD_WORD, 1'b0, 5'd9, 32'h0000_4002, 32'h0);
      tick();
      chk("inval.valid", {31'd0, bus.WB_Valid}, 32'd0);
      chk("inval.rw",    {31'd0, bus.WB_RegWrite}, 32'd0);
      chk("inval.mis",   {31'd0, bus.WB_Misaligned}, 32'd0);
      chk("inval.alu",   bus.WB_ALU_Result, 32'h0000_4002);

      // Capture Rd=7, then stall three cycles with changing inputs
      drive(1'b1, 1'b1, 1'b0, LOAD_WORD, 1'b0, 5'd7, 32'h0000_0077, 32'h0);
      tick();
      chk("cap7.rd", {27'd0, bus.WB_Write_Register}, 32'd7);
      bus.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, LOAD_BYTE, 1'b0, 5'(i + 10), 32'h1000 + 32'(i), 32'hFFFF_FFFF);
         tick();
         chk("stall.rd",  {27'd0, bus.WB_Write_Register}, 32'd7);
         chk("stall.alu", bus.WB_ALU_Result, 32'h0000_0077);
         chk("stall.sel", bus.WB_MemtoReg_Selector, 32'h0000_0000);
      end

      // Flush overrides stall
      bus.Flush = 1'b1;
      tick();
      chk_all_zero("flush");
      bus.Flush = 1'b0;
      bus.Stall = 1'b0;

      // Write to $0 is suppressed
      drive(1'b1, 1'b1, 1'b0, LOAD_WORD, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0);
      tick();
      chk("r0.rw",  {31'd0, bus.WB_RegWrite}, 32'd0);
      chk("r0.alu", bus.WB_ALU_Result, 32'hDEAD_BEEF);
      chk("r0.mux", wb_mux, 32'hDEAD_BEEF);

      // Reset released while stalled: stays at reset value until stall drops
      drive(1'b1, 1'b1, 1'b0, LOAD_WORD, 1'b0, 5'd12, 32'h0000_5555, 32'h0);
      reset     = 1'b0;
      bus.Stall = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      chk_all_zero("rststall");
      bus.Stall = 1'b0;
      tick();
      chk("rststall.alu", bus.WB_ALU_Result, 32'h0000_5555);
      chk("rststall.rd",  {27'd0, bus.WB_Write_Register}, 32'd12);
      chk("rststall.rw",  {31'd0, bus.WB_RegWrite}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_wb_register
